// File: rtl/rapcores_wb_pkg.sv
// Shared register map, bit indices and STATUS packing for the RAPcores Wishbone bridge.
// Pure declarations: no latency, no backpressure.
package rapcores_wb_pkg;

  localparam int CMD_W = 64;

  localparam logic [5:0] OFF_CMD_LO = 6'h00;
  localparam logic [5:0] OFF_CMD_HI = 6'h01;
  localparam logic [5:0] OFF_RSP_LO = 6'h02;
  localparam logic [5:0] OFF_RSP_HI = 6'h03;
  localparam logic [5:0] OFF_STATUS = 6'h04;
  localparam logic [5:0] OFF_CTRL   = 6'h05;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_OVF      = 4;
  localparam int ST_UNF      = 5;
  localparam int ST_TX_CNT   = 8;
  localparam int ST_RX_CNT   = 12;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  function automatic logic [31:0] pack_status(
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_full,
    input logic       rx_empty,
    input logic       ovf,
    input logic       unf,
    input logic [3:0] tx_cnt,
    input logic [3:0] rx_cnt
  );
    logic [31:0] s;
    s = '0;
    s[ST_TX_FULL]      = tx_full;
    s[ST_TX_EMPTY]     = tx_empty;
    s[ST_RX_FULL]      = rx_full;
    s[ST_RX_EMPTY]     = rx_empty;
    s[ST_OVF]          = ovf;
    s[ST_UNF]          = unf;
    s[ST_TX_CNT +: 4]  = tx_cnt;
    s[ST_RX_CNT +: 4]  = rx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/rapcores_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and synchronous flush.
// Head visible the cycle after a push; push accepted when not full or when popping in the same cycle; flush beats push.
module rapcores_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rapcores_wb_bridge.sv
// Wishbone classic slave bridging 32-bit bus accesses to 64-bit RAPcores command/response FIFOs.
// Ack one cycle after the hit (every other cycle on a held strobe); full TX drops writes, empty RX reads 0. Macro RAPCORES_WB_IRQ_EN adds irq_o.
module rapcores_wb_bridge
  import rapcores_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK  = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
`ifdef RAPCORES_WB_IRQ_EN
  output logic             irq_o,
`endif
  output logic             cmd_valid_o,
  output logic [CMD_W-1:0] cmd_data_o,
  input  logic             cmd_ready_i,
  input  logic             rsp_valid_i,
  input  logic [CMD_W-1:0] rsp_data_i,
  output logic             rsp_ready_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [5:0]       off;
  logic             hit, acc, wr, rd;
  logic [31:0]      cmd_lo;
  logic             enable, flush_q, irq_en;
  logic             ovf, unf;
  logic [31:0]      rd_val;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [CMD_W-1:0] tx_head;
  logic [CW-1:0]    tx_count;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [CMD_W-1:0] rx_head;
  logic [CW-1:0]    rx_count;

  assign off = wbs_adr_i[7:2];
  assign hit = wbs_cyc_i & wbs_stb_i & (((wbs_adr_i ^ BASE_ADDR) & ADDR_MASK) == 32'd0);
  assign acc = hit & ~wbs_ack_o;
  assign wr  = acc & wbs_we_i & (wbs_sel_i != 4'd0);
  assign rd  = acc & ~wbs_we_i;

  assign tx_push     = wr & (off == OFF_CMD_HI) & ~tx_full;
  assign tx_pop      = cmd_valid_o & cmd_ready_i;
  assign cmd_valid_o = enable & ~tx_empty;
  assign cmd_data_o  = cmd_valid_o ? tx_head : '0;

  // A same-cycle RSP_HI pop frees a slot, so a full RX FIFO can still take a response.
  assign rx_pop      = rd & (off == OFF_RSP_HI);
  assign rsp_ready_o = enable & (~rx_full | (rx_pop & ~rx_empty));
  assign rx_push     = rsp_valid_i & rsp_ready_o;

  rapcores_sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .flush    (flush_q),
    .push     (tx_push),
    .push_dat ({wbs_dat_i, cmd_lo}),
    .pop      (tx_pop),
    .head_dat (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count)
  );

  rapcores_sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .flush    (flush_q),
    .push     (rx_push),
    .push_dat (rsp_data_i),
    .pop      (rx_pop),
    .head_dat (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count)
  );

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CMD_LO: rd_val = cmd_lo;
      OFF_RSP_LO: rd_val = rx_empty ? 32'd0 : rx_head[31:0];
      OFF_RSP_HI: rd_val = rx_empty ? 32'd0 : rx_head[63:32];
      OFF_STATUS: rd_val = pack_status(tx_full, tx_empty, rx_full, rx_empty, ovf, unf,
                                       4'(tx_count), 4'(rx_count));
      OFF_CTRL:   rd_val = {29'd0, irq_en, 1'b0, enable};
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      cmd_lo    <= '0;
      enable    <= 1'b0;
      flush_q   <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rd_val : 32'd0;
      flush_q   <= 1'b0;
      if (wr) begin
        case (off)
          OFF_CMD_LO: cmd_lo <= wbs_dat_i;
          OFF_STATUS: begin
            if (wbs_dat_i[ST_OVF]) ovf <= 1'b0;
            if (wbs_dat_i[ST_UNF]) unf <= 1'b0;
          end
          OFF_CTRL: begin
            enable  <= wbs_dat_i[CTRL_EN];
            flush_q <= wbs_dat_i[CTRL_FLUSH];
          end
          default: ;
        endcase
      end
      // A full FIFO that is being flushed loses the word silently.
      if (wr && off == OFF_CMD_HI && tx_full && !flush_q) ovf <= 1'b1;
      if (rx_pop && rx_empty) unf <= 1'b1;
    end
  end

`ifdef RAPCORES_WB_IRQ_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (wr && off == OFF_CTRL) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      irq_o <= irq_en & (~rx_empty | ovf | unf);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_rapcores_wb_bridge.sv
// Directed, table-driven bench for rapcores_wb_bridge plus hand sequences for FIFO and reset corners.
module tb_rapcores_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [63:0] cmd_data;
  logic        rsp_valid = 1'b0, rsp_ready;
  logic [63:0] rsp_data = '0;
`ifdef RAPCORES_WB_IRQ_EN
  logic        irq;
`endif

  localparam logic [31:0] BASE = 32'h3000_0000;

  rapcores_wb_bridge dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
`ifdef RAPCORES_WB_IRQ_EN
    .irq_o       (irq),
`endif
    .cmd_valid_o (cmd_valid),
    .cmd_data_o  (cmd_data),
    .cmd_ready_i (cmd_ready),
    .rsp_valid_i (rsp_valid),
    .rsp_data_i  (rsp_data),
    .rsp_ready_o (rsp_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          ph;
    bit          we;
    logic [7:0]  off;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int ph, input bit w, input logic [7:0] off,
                     input logic [31:0] wd, input logic [3:0] s, input logic [31:0] exp);
    vec_t v;
    v.ph = ph; v.we = w; v.off = off; v.wd = wd; v.sel = s; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the ack edge (hold=1) or after one idle edge.
  task automatic wb_xfer(input bit w, input logic [7:0] off, input logic [31:0] wd,
                         input logic [3:0] s, input bit hold, output logic [31:0] rd);
    int lat;
    adr = BASE | {24'd0, off}; wdat = wd; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 8);
    rd = rdat;
    chk($sformatf("ack_lat_%02h", off), 64'(lat), 64'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    if (!hold) begin
      @(posedge clk); #1;
      if (!w) chk($sformatf("idle_after_%02h", off), {31'd0, ack, rdat}, 64'd0);
    end
  endtask

  task automatic run_phase(input int p);
    logic [31:0] rd;
    foreach (tbl[i]) begin
      if (tbl[i].ph == p) begin
        wb_xfer(tbl[i].we, tbl[i].off, tbl[i].wd, tbl[i].sel, 1'b0, rd);
        if (!tbl[i].we) chk($sformatf("v%0d_rd_%02h", i, tbl[i].off), 64'(rd), 64'(tbl[i].exp));
      end
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    bit seen;

    // phase 0: reset values, enable, one command
    add(0, 0, 8'h10, 0, 4'hF, 32'h0000_000A);
    add(0, 0, 8'h14, 0, 4'hF, 32'h0);
    add(0, 1, 8'h14, 32'h1, 4'hF, 0);
    add(0, 0, 8'h14, 0, 4'hF, 32'h1);
    add(0, 1, 8'h00, 32'hDEAD_BEEF, 4'hF, 0);
    add(0, 0, 8'h00, 0, 4'hF, 32'hDEAD_BEEF);
    add(0, 1, 8'h04, 32'h1, 4'hF, 0);
    add(0, 0, 8'h10, 0, 4'hF, 32'h0000_0108);
    // phase 1: fill TX, overflow, W1C, sel==0, unmapped
    add(1, 0, 8'h10, 0, 4'hF, 32'h0000_000A);
    add(1, 1, 8'h00, 32'hA0A0_0000, 4'hF, 0);
    add(1, 1, 8'h04, 32'h2, 4'hF, 0);
    add(1, 1, 8'h04, 32'h3, 4'hF, 0);
    add(1, 1, 8'h04, 32'h4, 4'hF, 0);
    add(1, 1, 8'h04, 32'h5, 4'hF, 0);
    add(1, 0, 8'h10, 0, 4'hF, 32'h0000_0409);
    add(1, 1, 8'h04, 32'h6, 4'hF, 0);
    add(1, 0, 8'h10, 0, 4'hF, 32'h0000_0419);
    add(1, 1, 8'h10, 32'h10, 4'hF, 0);
    add(1, 0, 8'h10, 0, 4'hF, 32'h0000_0409);
    add(1, 1, 8'h14, 32'h0, 4'h0, 0);
    add(1, 0, 8'h14, 0, 4'hF, 32'h1);
    add(1, 1, 8'h20, 32'hFFFF_FFFF, 4'hF, 0);
    add(1, 0, 8'h20, 0, 4'hF, 32'h0);
    add(1, 0, 8'hFC, 0, 4'hF, 32'h0);
    // phase 2: RX read-back, underflow
    add(2, 0, 8'h08, 0, 4'hF, 32'h9ABC_DEF0);
    add(2, 0, 8'h0C, 0, 4'hF, 32'h1234_5678);
    add(2, 0, 8'h10, 0, 4'hF, 32'h0000_0308);
    add(2, 0, 8'h0C, 0, 4'hF, 32'h0);
    add(2, 0, 8'h10, 0, 4'hF, 32'h0000_0328);
    add(2, 1, 8'h10, 32'h30, 4'hF, 0);
    add(2, 0, 8'h10, 0, 4'hF, 32'h0000_0308);
    // phase 3: after RX full push+pop, then flush both FIFOs
    add(3, 0, 8'h10, 0, 4'hF, 32'h0000_4304);
    add(3, 0, 8'h08, 0, 4'hF, 32'h2000_0001);
    add(3, 0, 8'h0C, 0, 4'hF, 32'h1000_0001);
    add(3, 0, 8'h10, 0, 4'hF, 32'h0000_3300);
    add(3, 1, 8'h04, 32'h7, 4'hF, 0);
    add(3, 0, 8'h10, 0, 4'hF, 32'h0000_3401);
    add(3, 1, 8'h14, 32'h3, 4'hF, 0);
    add(3, 0, 8'h10, 0, 4'hF, 32'h0000_000A);
    add(3, 0, 8'h14, 0, 4'hF, 32'h1);
    // phase 4: flush beat a coincident response
    add(4, 0, 8'h10, 0, 4'hF, 32'h0000_000A);
`ifndef RAPCORES_WB_IRQ_EN
    add(5, 1, 8'h14, 32'h5, 4'hF, 0);
    add(5, 0, 8'h14, 0, 4'hF, 32'h1);
`endif
    // phase 6: state after mid-transaction reset
    add(6, 0, 8'h10, 0, 4'hF, 32'h0000_000A);
    add(6, 0, 8'h14, 0, 4'hF, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {ack, cmd_valid, rsp_ready, rdat, cmd_data[31:0] | cmd_data[63:32]}, 0);
    rst_n = 1'b1;
    step();

    run_phase(0);
    chk("cmd_valid_one", 64'(cmd_valid), 64'd1);
    chk("cmd_data_one", cmd_data, 64'h0000_0001_DEAD_BEEF);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    chk("cmd_valid_drained", 64'(cmd_valid), 64'd0);

    run_phase(1);
    chk("cmd_head_fifo", cmd_data, 64'h0000_0002_A0A0_0000);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    chk("cmd_head_next", cmd_data, 64'h0000_0003_A0A0_0000);

    // miss: address outside the decoded window never acks
    adr = BASE + 32'h100; cyc = 1'b1; stb = 1'b1; we = 1'b0; seen = 1'b0;
    repeat (3) begin step(); seen |= ack; end
    cyc = 1'b0; stb = 1'b0;
    chk("miss_no_ack", 64'(seen), 64'd0);

    rsp_valid = 1'b1; rsp_data = 64'h1234_5678_9ABC_DEF0;
    chk("rsp_ready_empty", 64'(rsp_ready), 64'd1);
    step(); rsp_valid = 1'b0;
    run_phase(2);

    for (int k = 0; k < 4; k++) begin
      rsp_valid = 1'b1;
      rsp_data = {32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k)};
      chk($sformatf("rsp_ready_fill%0d", k), 64'(rsp_ready), 64'd1);
      step();
    end
    rsp_valid = 1'b0;
    chk("rsp_ready_full", 64'(rsp_ready), 64'd0);
    // RSP_HI pop on a full RX FIFO opens a slot for a response in the same cycle
    adr = BASE | 32'h0C; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    rsp_valid = 1'b1; rsp_data = 64'h5555_6666_7777_8888;
    #1;
    chk("rsp_ready_full_pop", 64'(rsp_ready), 64'd1);
    @(posedge clk); #1;
    chk("full_pop_rd", {31'd0, ack, rdat}, {31'd0, 1'b1, 32'h1000_0000});
    cyc = 1'b0; stb = 1'b0; rsp_valid = 1'b0;
    step();
    run_phase(3);

    wb_xfer(1'b1, 8'h14, 32'h3, 4'hF, 1'b1, rd);
    rsp_valid = 1'b1; rsp_data = 64'hCAFE;
    step(); rsp_valid = 1'b0;
    step();
    run_phase(4);

`ifdef RAPCORES_WB_IRQ_EN
    wb_xfer(1'b1, 8'h14, 32'h5, 4'hF, 1'b0, rd);
    wb_xfer(1'b0, 8'h14, 0, 4'hF, 1'b0, rd);
    chk("ctrl_irq_en", 64'(rd), 64'h5);
    chk("irq_idle", 64'(irq), 64'd0);
    rsp_valid = 1'b1; rsp_data = 64'h1;
    step(); rsp_valid = 1'b0;
    step();
    chk("irq_set", 64'(irq), 64'd1);
    step();
    chk("irq_held", 64'(irq), 64'd1);
    wb_xfer(1'b0, 8'h0C, 0, 4'hF, 1'b0, rd);
    chk("irq_popped", 64'(irq), 64'd0);
    wb_xfer(1'b1, 8'h14, 32'h1, 4'hF, 1'b0, rd);
`else
    run_phase(5);
`endif

    // reset lands while the strobe is held and an ack is showing
    wb_xfer(1'b1, 8'h04, 32'h9, 4'hF, 1'b0, rd);
    chk("pre_reset_valid", 64'(cmd_valid), 64'd1);
    adr = BASE | 32'h10; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    step();
    chk("pre_reset_ack", 64'(ack), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_ack_dropped", {ack, cmd_valid, rsp_ready, rdat}, 0);
    chk("rst_cmd_data", cmd_data, 64'd0);
    step();
    chk("rst_held_stb", 64'(ack), 64'd0);
`ifdef RAPCORES_WB_IRQ_EN
    chk("rst_irq", 64'(irq), 64'd0);
`endif
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    step();
    run_phase(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
